// File: rtl/act_pipe_sequencer_if.sv
// Signal bundle between act_pipe_sequencer and its environment: command,
// accumulator read port, activation pipeline links and UB write port.
interface act_pipe_sequencer_if #(
    parameter int unsigned AW    = 10,
    parameter int unsigned LEN_W = 16
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [AW-1:0]       cmd_acc_base;
    logic [AW-1:0]       cmd_ub_base;
    logic [LEN_W-1:0]    cmd_len;
    logic                cmd_loss_en;
    logic signed [15:0]  cmd_norm_gain;
    logic signed [31:0]  cmd_norm_bias;
    logic [4:0]          cmd_norm_shift;
    logic signed [15:0]  cmd_q_inv_scale;
    logic signed [7:0]   cmd_q_zero_point;

    logic                acc_rd_en;
    logic [AW-1:0]       acc_rd_addr;
    logic [31:0]         acc_rd_data;
    logic [31:0]         tgt_rd_data;

    logic                pipe_valid_in;
    logic [31:0]         pipe_acc_in;
    logic [31:0]         pipe_target_in;
    logic signed [15:0]  norm_gain;
    logic signed [31:0]  norm_bias;
    logic [4:0]          norm_shift;
    logic signed [15:0]  q_inv_scale;
    logic signed [7:0]   q_zero_point;
    logic                pipe_valid_out;
    logic [7:0]          pipe_ub_data;
    logic                pipe_loss_valid;
    logic signed [31:0]  pipe_loss;

    logic                ub_wr_en;
    logic [AW-1:0]       ub_wr_addr;
    logic [7:0]          ub_wr_data;
    logic                ub_wr_ready;

    logic                busy;
    logic                done;
    logic signed [47:0]  loss_sum;

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_acc_base, cmd_ub_base, cmd_len, cmd_loss_en,
               cmd_norm_gain, cmd_norm_bias, cmd_norm_shift, cmd_q_inv_scale,
               cmd_q_zero_point, acc_rd_data, tgt_rd_data, pipe_valid_out,
               pipe_ub_data, pipe_loss_valid, pipe_loss, ub_wr_ready,
        output cmd_ready, acc_rd_en, acc_rd_addr, pipe_valid_in, pipe_acc_in,
               pipe_target_in, norm_gain, norm_bias, norm_shift, q_inv_scale,
               q_zero_point, ub_wr_en, ub_wr_addr, ub_wr_data, busy, done,
               loss_sum
    );

    // Environment side (control FSM, memories, pipeline, UB).
    modport master (
        output cmd_valid, cmd_acc_base, cmd_ub_base, cmd_len, cmd_loss_en,
               cmd_norm_gain, cmd_norm_bias, cmd_norm_shift, cmd_q_inv_scale,
               cmd_q_zero_point, acc_rd_data, tgt_rd_data, pipe_valid_out,
               pipe_ub_data, pipe_loss_valid, pipe_loss, ub_wr_ready,
        input  cmd_ready, acc_rd_en, acc_rd_addr, pipe_valid_in, pipe_acc_in,
               pipe_target_in, norm_gain, norm_bias, norm_shift, q_inv_scale,
               q_zero_point, ub_wr_en, ub_wr_addr, ub_wr_data, busy, done,
               loss_sum
    );
endinterface

// File: rtl/act_pipe_sequencer.sv
// Streams a block of accumulator words through the activation pipeline into
// the UB, with a credit-limited output FIFO and per-job loss summation.
module act_pipe_sequencer #(
    parameter int unsigned AW         = 10,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned LEN_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    act_pipe_sequencer_if.slave bus
);
    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

    typedef struct packed {
        logic [AW-1:0]    acc_base;
        logic [AW-1:0]    ub_base;
        logic [LEN_W-1:0] len;
        logic             loss_en;
        logic [15:0]      gain;
        logic [31:0]      bias;
        logic [4:0]       shift;
        logic [15:0]      inv_scale;
        logic [7:0]       zero_point;
    } cfg_t;

    state_t             state_q, state_d;
    cfg_t               cfg_q;
    logic               rdy_q;
    logic               pv_q;
    logic [LEN_W-1:0]   issued_q, written_q;
    logic [CW-1:0]      in_flight_q, fifo_cnt_q;
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [7:0]         fifo_mem [FIFO_DEPTH];
    logic signed [47:0] loss_q;

    logic               accept, rd_en, busy_s, done_s;
    logic               push, pop, fifo_ne, fifo_full, push_ok, last_issue;
    logic [CW-1:0]      occupancy;

    assign accept     = bus.cmd_valid && rdy_q;
    assign occupancy  = in_flight_q + fifo_cnt_q;
    assign fifo_ne    = (fifo_cnt_q != '0);
    assign fifo_full  = (fifo_cnt_q == CW'(FIFO_DEPTH));
    // Returns are only accepted while a job is live, so stale pipeline
    // traffic after an abandoning reset never reaches the UB.
    assign push       = bus.pipe_valid_out && busy_s;
    assign pop        = fifo_ne && bus.ub_wr_ready;
    assign push_ok    = push && (!fifo_full || pop);
    assign last_issue = rd_en && ((issued_q + LEN_W'(1)) == cfg_q.len);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = (bus.cmd_len == '0) ? DONE : ISSUE;
            ISSUE:   if (last_issue) state_d = DRAIN;
            DRAIN:   if (written_q == cfg_q.len && in_flight_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State-decoded controls; reads issue only while credit remains.
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        rd_en  = 1'b0;
        case (state_q)
            ISSUE: begin
                busy_s = 1'b1;
                rd_en  = (occupancy < CW'(FIFO_DEPTH)) && (issued_q != cfg_q.len);
            end
            DRAIN:   busy_s = 1'b1;
            DONE:    done_s = 1'b1;
            default: ;
        endcase
    end

    // Command ready, low through reset and whenever the next state is not IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) rdy_q <= 1'b0;
        else       rdy_q <= (state_d == IDLE);
    end

    // Job configuration latched at acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)       cfg_q <= '0;
        else if (accept) cfg_q <= '{acc_base: bus.cmd_acc_base, ub_base: bus.cmd_ub_base,
                                    len: bus.cmd_len, loss_en: bus.cmd_loss_en,
                                    gain: bus.cmd_norm_gain, bias: bus.cmd_norm_bias,
                                    shift: bus.cmd_norm_shift,
                                    inv_scale: bus.cmd_q_inv_scale,
                                    zero_point: bus.cmd_q_zero_point};
    end

    // Issue/write/in-flight counters, pipeline valid delay and loss accumulator.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            issued_q    <= '0;
            written_q   <= '0;
            in_flight_q <= '0;
            pv_q        <= 1'b0;
            loss_q      <= '0;
        end else begin
            pv_q <= rd_en;
            if (accept) begin
                issued_q    <= '0;
                written_q   <= '0;
                in_flight_q <= '0;
                loss_q      <= '0;
            end else begin
                if (rd_en) issued_q  <= issued_q + LEN_W'(1);
                if (pop)   written_q <= written_q + LEN_W'(1);
                in_flight_q <= in_flight_q + CW'(rd_en) - CW'(push);
                if (bus.pipe_loss_valid && cfg_q.loss_en && busy_s)
                    loss_q <= loss_q + {{16{bus.pipe_loss[31]}}, bus.pipe_loss};
            end
        end
    end

    // Output FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)     rd_ptr_q <= rd_ptr_q + PW'(1);
            fifo_cnt_q <= fifo_cnt_q + CW'(push_ok) - CW'(pop);
        end
    end

    // Output FIFO storage.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= bus.pipe_ub_data;
    end

    overflow_chk: assert property (@(posedge clk) disable iff (reset)
                                   !(push && fifo_full && !pop));

    assign bus.cmd_ready      = rdy_q;
    assign bus.acc_rd_en      = rd_en;
    assign bus.acc_rd_addr    = rd_en ? (cfg_q.acc_base + AW'(issued_q)) : '0;
    assign bus.pipe_valid_in  = pv_q;
    assign bus.pipe_acc_in    = pv_q ? bus.acc_rd_data : '0;
    assign bus.pipe_target_in = (pv_q && cfg_q.loss_en) ? bus.tgt_rd_data : '0;
    assign bus.norm_gain      = cfg_q.gain;
    assign bus.norm_bias      = cfg_q.bias;
    assign bus.norm_shift     = cfg_q.shift;
    assign bus.q_inv_scale    = cfg_q.inv_scale;
    assign bus.q_zero_point   = cfg_q.zero_point;
    assign bus.ub_wr_en       = fifo_ne;
    assign bus.ub_wr_addr     = cfg_q.ub_base + AW'(written_q);
    assign bus.ub_wr_data     = fifo_ne ? fifo_mem[rd_ptr_q] : '0;
    assign bus.busy           = busy_s;
    assign bus.done           = done_s;
    assign bus.loss_sum       = loss_q;
endmodule

// File: tb/tb_act_pipe_sequencer.sv
// Scoreboard bench for act_pipe_sequencer with a 3-cycle stub pipeline.
module tb_act_pipe_sequencer;
    localparam int unsigned AW    = 10;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned LEN_W = 16;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    act_pipe_sequencer_if #(.AW(AW), .LEN_W(LEN_W)) bus ();

    act_pipe_sequencer #(.AW(AW), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int done_cnt = 0, wr_cnt = 0, rd_cnt = 0, max_occ = 0;
    logic exp_tgt_en = 1'b0;
    wr_t  exp_q[$];
    logic [47:0] loss_exp_q[$];

    logic [31:0] acc_mem [1024];
    logic [31:0] tgt_mem [1024];

    always @(posedge clk) cyc++;

    // Accumulator/target memory: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.acc_rd_en) begin
            bus.acc_rd_data <= acc_mem[bus.acc_rd_addr];
            bus.tgt_rd_data <= tgt_mem[bus.acc_rd_addr];
        end
    end

    // Stub pipeline: echoes acc[7:0], loss is the raw target word.
    logic [2:0]  sv;
    logic [7:0]  sd [3];
    logic [31:0] sl [3];
    always @(posedge clk or posedge reset) begin
        if (reset) sv <= '0;
        else begin
            sv    <= {sv[1:0], bus.pipe_valid_in};
            sd[0] <= bus.pipe_acc_in[7:0];
            sd[1] <= sd[0];
            sd[2] <= sd[1];
            sl[0] <= bus.tgt_rd_data;
            sl[1] <= sl[0];
            sl[2] <= sl[1];
        end
    end
    assign bus.pipe_valid_out  = sv[2];
    assign bus.pipe_ub_data    = sd[2];
    assign bus.pipe_loss_valid = sv[2];
    assign bus.pipe_loss       = sl[2];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic any_output();
        return |{bus.cmd_ready, bus.acc_rd_en, bus.acc_rd_addr, bus.pipe_valid_in,
                 bus.pipe_acc_in, bus.pipe_target_in, bus.norm_gain, bus.norm_bias,
                 bus.norm_shift, bus.q_inv_scale, bus.q_zero_point, bus.ub_wr_en,
                 bus.ub_wr_addr, bus.ub_wr_data, bus.busy, bus.done, bus.loss_sum};
    endfunction

    // Monitor: pops the scoreboard on every completed UB write and on done.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.acc_rd_en) rd_cnt++;
            if (bus.pipe_valid_in)
                chk("pipe_target_in", {32'b0, bus.pipe_target_in},
                    exp_tgt_en ? {32'b0, bus.tgt_rd_data} : 64'b0);
            if (bus.ub_wr_en && bus.ub_wr_ready) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL ub_write unexpected: addr=%0h data=%0h", bus.ub_wr_addr, bus.ub_wr_data);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("ub_wr_addr", {54'b0, bus.ub_wr_addr}, {54'b0, e.addr});
                    chk("ub_wr_data", {56'b0, bus.ub_wr_data}, {56'b0, e.data});
                end
            end
            if (rd_cnt - wr_cnt > max_occ) max_occ = rd_cnt - wr_cnt;
            if (bus.done) begin
                done_cnt++;
                chk("writes_pending_at_done", 64'(exp_q.size()), 64'd0);
                if (loss_exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL done unexpected: loss_sum=%0h", bus.loss_sum);
                end else
                    chk("loss_sum", {16'b0, bus.loss_sum}, {16'b0, loss_exp_q.pop_front()});
            end
        end
    end

    // Issue one job; optionally release backpressure after hold cycles or
    // abandon the job with a reset after abort_at completed writes.
    task automatic run_job(input logic [AW-1:0] ab, input logic [AW-1:0] ub, input int len,
                           input bit le, input logic [47:0] exp_loss, input int hold,
                           input int abort_at, output int lat);
        int n;
        int acc_cyc;
        int d0;
        lat = -1;
        exp_tgt_en = le;
        for (int k = 0; k < len; k++)
            exp_q.push_back('{addr: AW'(ub + AW'(k)), data: acc_mem[AW'(ab + AW'(k))][7:0]});
        loss_exp_q.push_back(exp_loss);
        rd_cnt = 0;
        wr_cnt = 0;
        max_occ = 0;
        d0 = done_cnt;
        bus.cmd_acc_base     = ab;
        bus.cmd_ub_base      = ub;
        bus.cmd_len          = LEN_W'(len);
        bus.cmd_loss_en      = le;
        bus.cmd_norm_gain    = 16'sh1234;
        bus.cmd_norm_bias    = 32'shDEADBEEF;
        bus.cmd_norm_shift   = 5'd5;
        bus.cmd_q_inv_scale  = 16'sh0180;
        bus.cmd_q_zero_point = 8'shF6;
        bus.cmd_valid        = 1'b1;
        n = 0;
        while (!bus.cmd_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: cmd_ready stayed 0");
            bus.cmd_valid = 1'b0;
            return;
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            bus.ub_wr_ready = 1'b1;
        end
        if (abort_at > 0) begin
            n = 0;
            while (wr_cnt < abort_at && n < 500) begin
                @(negedge clk);
                #1 n++;
            end
            chk("abort_reached", 64'(wr_cnt), 64'(abort_at));
            @(posedge clk);
            #1 reset = 1'b1;
            #1 chk("outputs_in_reset", 64'(any_output()), 64'd0);
            repeat (2) @(negedge clk);
            exp_q.delete();
            loss_exp_q.delete();
            reset = 1'b0;
            repeat (20) @(negedge clk);
            chk("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
            chk("no_writes_after_abort", 64'(wr_cnt), 64'(abort_at));
            return;
        end
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(negedge clk);
            #1 n++;
        end
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL done_timeout: no done pulse");
            return;
        end
        lat = cyc - acc_cyc;
        @(negedge clk);
        #1;
        chk("busy_after_done", 64'(bus.busy), 64'd0);
        chk("done_single_cycle", 64'(bus.done), 64'd0);
        repeat (3) @(negedge clk);
        chk("done_pulse_count", 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 1024; i++) begin
            acc_mem[i] = 32'h5A5A_0000 | 32'(i);
            tgt_mem[i] = 32'h0;
        end
        acc_mem[16] = 32'd1;
        acc_mem[17] = 32'd2;
        acc_mem[18] = 32'd3;
        acc_mem[19] = 32'd4;
        tgt_mem[32] = 32'd5;
        tgt_mem[33] = 32'hFFFF_FFFE;
        tgt_mem[34] = 32'd7;
        bus.cmd_valid = 1'b0;
        bus.cmd_acc_base = '0;
        bus.cmd_ub_base = '0;
        bus.cmd_len = '0;
        bus.cmd_loss_en = 1'b0;
        bus.cmd_norm_gain = '0;
        bus.cmd_norm_bias = '0;
        bus.cmd_norm_shift = '0;
        bus.cmd_q_inv_scale = '0;
        bus.cmd_q_zero_point = '0;
        bus.ub_wr_ready = 1'b1;

        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'(any_output()), 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        chk("idle_busy", 64'(bus.busy), 64'd0);

        // Basic: writes (0x40,1) (0x41,2) (0x42,3) (0x43,4).
        run_job(10'h010, 10'h040, 4, 1'b0, 48'd0, 0, 0, lat);
        chk("cfg_norm_gain", {48'b0, bus.norm_gain}, 64'h1234);
        chk("cfg_norm_bias", {32'b0, bus.norm_bias}, 64'hDEADBEEF);
        chk("cfg_norm_shift", {59'b0, bus.norm_shift}, 64'd5);
        chk("cfg_q_inv_scale", {48'b0, bus.q_inv_scale}, 64'h0180);
        chk("cfg_q_zero_point", {56'b0, bus.q_zero_point}, 64'hF6);

        // Loss: 5 + (-2) + 7 = 10, then the same job with loss disabled.
        run_job(10'h020, 10'h060, 3, 1'b1, 48'd10, 0, 0, lat);
        run_job(10'h020, 10'h060, 3, 1'b0, 48'd0, 0, 0, lat);

        // Zero-length job: done one cycle after acceptance, no traffic.
        run_job(10'h000, 10'h000, 0, 1'b0, 48'd0, 0, 0, lat);
        chk("len0_done_latency", 64'(lat), 64'd1);
        chk("len0_reads", 64'(rd_cnt), 64'd0);
        chk("len0_writes", 64'(wr_cnt), 64'd0);

        // UB address wrap: 0x3FE, 0x3FF, 0x000, 0x001.
        run_job(10'h030, 10'h3FE, 4, 1'b0, 48'd0, 0, 0, lat);

        // Backpressure: ready low for 30 cycles; occupancy caps at the FIFO depth.
        bus.ub_wr_ready = 1'b0;
        run_job(10'h200, 10'h100, 20, 1'b0, 48'd0, 30, 0, lat);
        chk("bp_max_occupancy", 64'(max_occ), 64'(DEPTH));
        chk("bp_write_count", 64'(wr_cnt), 64'd20);

        // Reset after 5 of 16 writes, then a fresh two-element job.
        run_job(10'h300, 10'h200, 16, 1'b0, 48'd0, 0, 5, lat);
        run_job(10'h010, 10'h050, 2, 1'b0, 48'd0, 0, 0, lat);
        chk("fresh_write_count", 64'(wr_cnt), 64'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/act_pipe_sequencer.md
Name: act_pipe_sequencer

Overview:
Command-driven controller that streams a contiguous block of accumulator words through the activation/normalize/quantize pipeline and writes the int8 results to the unified buffer. It latches per-job normalization and quantization configuration, generates accumulator read addresses and UB write addresses, and absorbs UB backpressure with a credit-limited output FIFO. It also sums per-element loss over the job. It sits between the top-level control FSM, the accumulator memory, the activation pipeline and the unified buffer.

Parameters:
AW, 10, address width for accumulator and UB.
FIFO_DEPTH, 8, output FIFO entries; also the in-flight credit limit. Power of two, ≥ 4.
LEN_W, 16, width of the element-count field.

Ports:
clk  in  1  clock
reset  in  1  async active-high reset
cmd_valid  in  1  job request
cmd_ready  out  1  high only in IDLE
cmd_acc_base  in  AW  first accumulator address
cmd_ub_base  in  AW  first UB address
cmd_len  in  LEN_W  element count; 0 is legal
cmd_loss_en  in  1  enables loss summation
cmd_norm_gain  in  16  signed
cmd_norm_bias  in  32  signed
cmd_norm_shift  in  5
cmd_q_inv_scale  in  16  signed Q8.8
cmd_q_zero_point  in  8  signed
acc_rd_en  out  1  accumulator/target read strobe
acc_rd_addr  out  AW
acc_rd_data  in  32  valid exactly 1 cycle after acc_rd_en
tgt_rd_data  in  32  target word, same timing as acc_rd_data
pipe_valid_in  out  1
pipe_acc_in  out  32
pipe_target_in  out  32
norm_gain/norm_bias/norm_shift/q_inv_scale/q_zero_point  out  16/32/5/16/8  latched configuration
pipe_valid_out  in  1
pipe_ub_data  in  8
pipe_loss_valid  in  1
pipe_loss  in  32  signed
ub_wr_en  out  1
ub_wr_addr  out  AW
ub_wr_data  out  8
ub_wr_ready  in  1  a write completes when ub_wr_en && ub_wr_ready
busy  out  1
done  out  1  one-cycle pulse
loss_sum  out  48  signed; held after done

Behaviour:
- Reset is clk and reset: reset is asynchronous, active-high; clock is clk. On reset, all outputs are 0, the FSM returns to IDLE, the FIFO is emptied and all counters are cleared. Reset mid-job abandons the job: no done pulse, and no UB writes after reset deasserts until a new command is accepted.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE: cmd_ready=1. On cmd_valid, latch all cmd_* fields into config registers and clear loss_sum and the counters (issued, written, in_flight). Go to ISSUE if len>0, otherwise go directly to DONE.
- ISSUE: assert acc_rd_en with acc_rd_addr=acc_base+issued when credit>0.
  - credit = FIFO_DEPTH − in_flight − fifo_count.
  - in_flight increments on each acc_rd_en and decrements on each pipe_valid_out; a simultaneous increment and decrement leaves it unchanged.
  - Go to DRAIN in the cycle the last read issues (issued reaches len).
- Issue-to-pipeline timing: pipe_valid_in is acc_rd_en delayed by one register. pipe_acc_in and pipe_target_in are combinational pass-throughs of acc_rd_data and tgt_rd_data. pipe_target_in = 0 when loss_en=0.
- The config outputs are driven from the latched registers and held constant from command acceptance until the next acceptance.
- Pipeline returns: pipe_valid_out pushes pipe_ub_data into the FIFO. The credit rule guarantees the FIFO never overflows. An overflow is an assertion failure, and the data is dropped.
- UB writes: ub_wr_en = FIFO not empty; ub_wr_data = FIFO head; ub_wr_addr = ub_base + written.
  - Pop and increment written on ub_wr_en && ub_wr_ready.
  - Data and address are held stable while ready is low.
  - A push and a pop in the same cycle are both honoured.
  - Addresses wrap modulo 2^AW.
- Loss: when pipe_loss_valid && loss_en, loss_sum += sign-extended pipe_loss. The sum wraps in 48 bits (no saturation).
- DRAIN: go to DONE when written == len and in_flight == 0.
- DONE: done=1 for exactly one cycle, then IDLE. done fires for len=0 in the cycle after acceptance.
- busy = 1 whenever the FSM is in ISSUE or DRAIN.
- Commands are accepted only in IDLE, so the minimum gap between done and the next acceptance is 1 cycle.
- Element order is preserved end to end: the k-th read maps to UB address ub_base+k.

Test Plan:
- Basic: len=4, acc_base=0x10, ub_base=0x40, stub pipeline (3-cycle delay, echoes acc[7:0]), acc mem 1,2,3,4, ub_wr_ready=1 -> UB writes (0x40,1),(0x41,2),(0x42,3),(0x43,4); a single done pulse; busy is low after done.
- Backpressure: len=20, FIFO_DEPTH=8, ub_wr_ready low for 30 cycles after start -> in_flight+fifo_count never exceeds 8, no FIFO overflow, all 20 writes arrive in order once ready rises.
- Loss: len=3, loss_en=1, stub pipe_loss = 5, −2, 7 -> loss_sum=10 at done. Repeat with loss_en=0 -> loss_sum=0 and pipe_target_in=0.
- len=0 -> done one cycle after acceptance, no acc_rd_en, no ub_wr_en.
- Wrap: AW=10, ub_base=0x3FE, len=4 -> write addresses 0x3FE, 0x3FF, 0x000, 0x001.
- Reset mid-job: assert reset after 5 of 16 writes -> all outputs 0, no done, no further writes. A fresh len=2 job then completes correctly.
